// File: rtl/imem_load_ctrl.sv
// ---------------------------------------------------------------------------
// imem_load_ctrl
//
// Owns the single port of the instruction memory. In RUN the CPU fetch
// address passes straight through (combinational, no added latency). On
// load_start the CPU is stalled, a byte-serial program stream is packed
// big-endian into 32-bit words and written from address 0 upward. The load
// ends after NWORDS writes or on load_end; a partial word is written
// left-justified and zero-padded.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   cpu_a             CPU fetch word address
//   load_start        one-cycle request to begin a program load
//   load_end          one-cycle request to end the load early
//   byte_valid/data   loader byte stream
//   byte_ready        a byte is accepted this cycle when byte_valid is high
//   mem_a/we/wd       instruction memory address, write enable, write data
//   cpu_stall         freezes PC/fetch while high
//   load_done         one-cycle pulse in the first RUN cycle after a load
//   words_loaded      number of words written by the last load (0..NWORDS)
//   load_checksum     (only with IMEM_LOAD_CHECKSUM_EN defined) modulo-2^32
//                     sum of all words written by the current load
//
// Optional feature macro: IMEM_LOAD_CHECKSUM_EN
// ---------------------------------------------------------------------------
module imem_load_ctrl #(
    parameter int AW     = 6,
    parameter int NWORDS = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] cpu_a,
    input  logic          load_start,
    input  logic          load_end,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic [AW-1:0] mem_a,
    output logic          mem_we,
    output logic [31:0]   mem_wd,
    output logic          cpu_stall,
    output logic          load_done,
    output logic [AW:0]   words_loaded
`ifdef IMEM_LOAD_CHECKSUM_EN
    ,
    output logic [31:0]   load_checksum
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NWORDS - 1);

    state_t        state_reg, state_next;
    logic [AW-1:0] wr_ptr_reg;
    logic [1:0]    byte_cnt_reg;
    logic [31:0]   word_reg;
    logic          end_pending_reg;

    // Combinational view of the byte being accepted this cycle.
    logic          accept;
    logic [2:0]    fill;        // bytes held after this cycle's accept (0..4)
    logic [31:0]   word_fill;   // shift register after this cycle's accept
    logic [31:0]   word_padded; // word_fill left-justified for a partial word

    assign mem_wd = word_reg;

    always_comb begin
        state_next = state_reg;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        cpu_stall  = 1'b0;
        mem_a      = cpu_a;
        accept     = 1'b0;
        fill       = {1'b0, byte_cnt_reg};
        word_fill  = word_reg;

        case (state_reg)
            RUN: begin
                if (load_start)
                    state_next = LOAD;
            end
            LOAD: begin
                cpu_stall  = 1'b1;
                byte_ready = 1'b1;
                mem_a      = wr_ptr_reg;
                accept     = byte_valid;
                if (accept) begin
                    word_fill = {word_reg[23:0], byte_data};
                    fill      = {1'b0, byte_cnt_reg} + 3'd1;
                end
                // A byte arriving with load_end is taken first, so a word it
                // completes is written before returning to RUN.
                if (fill == 3'd4)
                    state_next = WRITE;
                else if (load_end)
                    state_next = (fill == 3'd0) ? RUN : WRITE;
            end
            WRITE: begin
                cpu_stall = 1'b1;
                mem_we    = 1'b1;
                mem_a     = wr_ptr_reg;
                if (wr_ptr_reg == LAST_ADDR || end_pending_reg)
                    state_next = RUN;
                else
                    state_next = LOAD;
            end
            default: state_next = RUN;
        endcase
    end

    // Older bytes still sit in the upper lanes of the shift register, so the
    // partial word is rebuilt from the low lanes only.
    always_comb begin
        case (fill)
            3'd1:    word_padded = {word_fill[7:0], 24'd0};
            3'd2:    word_padded = {word_fill[15:0], 16'd0};
            3'd3:    word_padded = {word_fill[23:0], 8'd0};
            default: word_padded = word_fill;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= RUN;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg      <= '0;
            byte_cnt_reg    <= '0;
            word_reg        <= '0;
            end_pending_reg <= 1'b0;
            load_done       <= 1'b0;
            words_loaded    <= '0;
        end else begin
            load_done <= 1'b0;
            case (state_reg)
                RUN: begin
                    if (load_start) begin
                        wr_ptr_reg      <= '0;
                        byte_cnt_reg    <= '0;
                        end_pending_reg <= 1'b0;
                    end
                end
                LOAD: begin
                    if (state_next == WRITE) begin
                        word_reg        <= word_padded;
                        byte_cnt_reg    <= '0;
                        end_pending_reg <= load_end;
                    end else if (accept) begin
                        word_reg     <= word_fill;
                        byte_cnt_reg <= fill[1:0];
                    end
                    if (state_next == RUN) begin
                        load_done    <= 1'b1;
                        words_loaded <= {1'b0, wr_ptr_reg};
                    end
                end
                WRITE: begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (state_next == RUN) begin
                        load_done    <= 1'b1;
                        words_loaded <= {1'b0, wr_ptr_reg} + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            load_checksum <= '0;
        else if (state_reg == RUN && load_start)
            load_checksum <= '0;
        else if (state_reg == WRITE)
            load_checksum <= load_checksum + word_reg;
    end
`endif

endmodule

// File: tb/tb_imem_load_ctrl.sv
module tb_imem_load_ctrl;
    localparam int AW     = 6;
    localparam int NWORDS = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] cpu_a = '0;
    logic          load_start = 1'b0;
    logic          load_end = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_ready;
    logic [AW-1:0] mem_a;
    logic          mem_we;
    logic [31:0]   mem_wd;
    logic          cpu_stall;
    logic          load_done;
    logic [AW:0]   words_loaded;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0]   load_checksum;
`endif

    imem_load_ctrl #(.AW(AW), .NWORDS(NWORDS)) dut (
        .clk(clk), .reset(reset), .cpu_a(cpu_a),
        .load_start(load_start), .load_end(load_end),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd),
        .cpu_stall(cpu_stall), .load_done(load_done), .words_loaded(words_loaded)
`ifdef IMEM_LOAD_CHECKSUM_EN
        , .load_checksum(load_checksum)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Write log and a behavioural memory fed by the DUT's memory port.
    logic [AW-1:0] log_a[$];
    logic [31:0]   log_d[$];
    logic [31:0]   mem_model[NWORDS];
    int            done_cnt = 0;

    always @(posedge clk) begin
        if (mem_we) begin
            log_a.push_back(mem_a);
            log_d.push_back(mem_wd);
            mem_model[mem_a] = mem_wd;
        end
        if (load_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: bytes packed big-endian, last word zero-padded, at most NWORDS.
    function automatic int exp_count(input logic [7:0] b[$]);
        int n = (b.size() + 3) / 4;
        return (n > NWORDS) ? NWORDS : n;
    endfunction

    function automatic logic [31:0] exp_word(input logic [7:0] b[$], input int i);
        logic [31:0] w = 0;
        for (int k = 0; k < 4; k++) begin
            int idx = 4 * i + k;
            w = w * 256 + ((idx < b.size()) ? 32'(b[idx]) : 32'd0);
        end
        return w;
    endfunction

    task automatic start_load;
        log_a.delete();
        log_d.delete();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("stall_in_load", cpu_stall, 1);
    endtask

    // end_mode: 0 = none, 1 = load_end after the stream, 2 = load_end with last byte
    task automatic feed(input logic [7:0] b[$], input int end_mode, input bit gaps, input bit poke);
        int n;
        for (int i = 0; i < b.size(); i++) begin
            if (gaps) begin
                byte_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            byte_valid = 1'b1;
            byte_data  = b[i];
            n = 0;
            while (!byte_ready && n < 20) begin tick(); n++; end
            check("byte_ready_wait", byte_ready, 1);
            if (end_mode == 2 && i == b.size() - 1) load_end = 1'b1;
            if (poke && i == 5) load_start = 1'b1;
            tick();
            byte_valid = 1'b0;
            load_end   = 1'b0;
            load_start = 1'b0;
        end
        if (end_mode == 1) begin
            n = 0;
            while (!byte_ready && n < 20) begin tick(); n++; end
            check("end_ready_wait", byte_ready, 1);
            load_end = 1'b1;
            tick();
            load_end = 1'b0;
        end
    endtask

    task automatic finish_load(input string name, input logic [7:0] b[$]);
        int n = 0;
        int nw = exp_count(b);
        int dc;
        logic [31:0] sum = 0;
        while (!load_done && n < 20) begin tick(); n++; end
        check({name, "_done"}, load_done, 1);
        check({name, "_stall_low_at_done"}, cpu_stall, 0);
        check({name, "_words_loaded"}, words_loaded, nw);
        for (int i = 0; i < nw; i++) sum += exp_word(b, i);
`ifdef IMEM_LOAD_CHECKSUM_EN
        check({name, "_checksum"}, load_checksum, sum);
`endif
        dc = done_cnt;
        tick();
        check({name, "_done_one_cycle"}, load_done, 0);
        check({name, "_done_count"}, done_cnt, dc + 1);
        check({name, "_write_count"}, log_a.size(), nw);
        for (int i = 0; i < nw && i < log_a.size(); i++) begin
            check({name, "_addr"}, log_a[i], i);
            check({name, "_data"}, log_d[i], exp_word(b, i));
        end
        $display("[TB] load %s: %0d bytes, %0d words expected, checksum %08h", name, b.size(), nw, sum);
    endtask

    initial begin
        logic [7:0] b[$];
        int dc;

        // Reset state and RUN pass-through
        cpu_a = 6'd5;
        tick();
        check("rst_done", load_done, 0);
        check("rst_words", words_loaded, 0);
        check("rst_wd", mem_wd, 0);
        reset = 1'b0;
        tick();
        check("run_mem_a", mem_a, 5);
        check("run_we", mem_we, 0);
        check("run_stall", cpu_stall, 0);
        check("run_ready", byte_ready, 0);
        cpu_a = 6'd42;
        #1;
        check("run_mem_a_comb", mem_a, 42);

        // load_end in RUN is ignored
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        check("run_end_ign_stall", cpu_stall, 0);
        tick();
        check("run_end_ign_done", load_done, 0);

        // One word then explicit end
        b = '{8'h12, 8'h34, 8'h56, 8'h78};
        start_load();
        check("load_mem_a", mem_a, 0);
        feed(b, 1, 0, 0);
        finish_load("one_word", b);

        // Two words, end afterwards
        b = '{8'h20, 8'h08, 8'h00, 8'h01, 8'hAC, 8'h04, 8'h00, 8'h00};
        start_load();
        feed(b, 1, 0, 0);
        finish_load("two_words", b);

        // Partial word padding
        b = '{8'hAA, 8'hBB};
        start_load();
        feed(b, 1, 0, 0);
        finish_load("partial", b);

        // Immediate end: nothing written
        b.delete();
        start_load();
        feed(b, 1, 0, 0);
        finish_load("empty", b);

        // Random loads; load_end with the last byte; load_start mid-load ignored
        for (int t = 0; t < 4; t++) begin
            int len = $urandom_range(6, 30);
            b.delete();
            for (int i = 0; i < len; i++) b.push_back(8'($urandom));
            start_load();
            feed(b, 2, 1, 1);
            finish_load("rand_end_with_byte", b);
        end

        // Full memory: 256 random bytes, auto-terminate
        b.delete();
        for (int i = 0; i < 4 * NWORDS; i++) b.push_back(8'($urandom));
        start_load();
        feed(b, 0, 1, 0);
        finish_load("full", b);
        byte_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("full_no_ready", byte_ready, 0);
            tick();
        end
        byte_valid = 1'b0;
        check("full_no_extra_writes", log_a.size(), NWORDS);

        // Reset after 2 words + 1 byte
        b.delete();
        for (int i = 0; i < 9; i++) b.push_back(8'($urandom));
        start_load();
        feed(b, 0, 0, 0);
        dc = done_cnt;
        check("pre_rst_stall", cpu_stall, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_stall", cpu_stall, 0);
        check("mid_rst_ready", byte_ready, 0);
        check("mid_rst_mem_a", mem_a, cpu_a);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("mid_rst_no_done", done_cnt, dc);
        check("mid_rst_writes", log_a.size(), 2);
        check("mid_rst_mem0", mem_model[0], exp_word(b, 0));
        check("mid_rst_mem1", mem_model[1], exp_word(b, 1));
        $display("[TB] reset mid-load: %0d words retained", log_a.size());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
